// File: rtl/piezo_alert_seq.sv
// Prioritised piezo alert sequencer: per-mode tone pitch and beep on/off cadence,
// immediate escalation, de-escalation at pattern boundaries. Optional PIEZO_MUTE_EN adds a mute input.
module piezo_alert_seq #(
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned DUR_W     = 26,
  parameter int unsigned NORM_HALF = 33333,
  parameter int unsigned BATT_HALF = 16667,
  parameter int unsigned OVR_HALF  = 8333,
  parameter int unsigned NORM_ON   = 16777216,
  parameter int unsigned NORM_OFF  = 50331648,
  parameter int unsigned OVR_ON    = 16777216,
  parameter int unsigned OVR_OFF   = 16777216,
  parameter int unsigned BOTH_ON   = 8388608,
  parameter int unsigned BOTH_OFF  = 8388608
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       norm_mode,
  input  logic       ovr_spd,
  input  logic       batt_low,
`ifdef PIEZO_MUTE_EN
  input  logic       mute,
`endif
  output logic       piezo,
  output logic       piezo_n,
  output logic [2:0] active_mode,
  output logic       beep_on
);

  if (NORM_HALF < 1 || (NORM_HALF >> DIV_W) != 0) $error("NORM_HALF out of range");
  if (BATT_HALF < 1 || (BATT_HALF >> DIV_W) != 0) $error("BATT_HALF out of range");
  if (OVR_HALF  < 1 || (OVR_HALF  >> DIV_W) != 0) $error("OVR_HALF out of range");
  if (NORM_ON   < 1 || (NORM_ON   >> DUR_W) != 0) $error("NORM_ON out of range");
  if (NORM_OFF  < 1 || (NORM_OFF  >> DUR_W) != 0) $error("NORM_OFF out of range");
  if (OVR_ON    < 1 || (OVR_ON    >> DUR_W) != 0) $error("OVR_ON out of range");
  if (OVR_OFF   < 1 || (OVR_OFF   >> DUR_W) != 0) $error("OVR_OFF out of range");
  if (BOTH_ON   < 1 || (BOTH_ON   >> DUR_W) != 0) $error("BOTH_ON out of range");
  if (BOTH_OFF  < 1 || (BOTH_OFF  >> DUR_W) != 0) $error("BOTH_OFF out of range");

  localparam logic [DIV_W-1:0] NORM_HALF_M1 = DIV_W'(NORM_HALF - 1);
  localparam logic [DIV_W-1:0] BATT_HALF_M1 = DIV_W'(BATT_HALF - 1);
  localparam logic [DIV_W-1:0] OVR_HALF_M1  = DIV_W'(OVR_HALF - 1);
  localparam logic [DUR_W-1:0] NORM_ON_M1   = DUR_W'(NORM_ON - 1);
  localparam logic [DUR_W-1:0] NORM_OFF_M1  = DUR_W'(NORM_OFF - 1);
  localparam logic [DUR_W-1:0] OVR_ON_M1    = DUR_W'(OVR_ON - 1);
  localparam logic [DUR_W-1:0] OVR_OFF_M1   = DUR_W'(OVR_OFF - 1);
  localparam logic [DUR_W-1:0] BOTH_ON_M1   = DUR_W'(BOTH_ON - 1);
  localparam logic [DUR_W-1:0] BOTH_OFF_M1  = DUR_W'(BOTH_OFF - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

  state_t           state, state_nxt;
  logic [2:0]       req, mode_nxt;
  logic             phase_start, drive, tone;
  logic [DUR_W-1:0] dur, on_lim, off_lim;
  logic [DIV_W-1:0] div, half_lim;

  assign req = (ovr_spd && batt_low) ? 3'd4 :
               ovr_spd               ? 3'd3 :
               batt_low              ? 3'd2 :
               norm_mode             ? 3'd1 : 3'd0;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin : limits
    half_lim = NORM_HALF_M1;
    on_lim   = NORM_ON_M1;
    off_lim  = NORM_OFF_M1;
    unique case (active_mode)
      3'd2:    half_lim = BATT_HALF_M1;
      3'd3:    begin half_lim = OVR_HALF_M1; on_lim = OVR_ON_M1;  off_lim = OVR_OFF_M1;  end
      3'd4:    begin half_lim = OVR_HALF_M1; on_lim = BOTH_ON_M1; off_lim = BOTH_OFF_M1; end
      default: ;
    endcase
  end

  // active_mode is 0 whenever IDLE, so the escalation test also covers IDLE -> ON.
  always_comb begin : next_state
    state_nxt   = state;
    mode_nxt    = active_mode;
    phase_start = 1'b0;
    if (req > active_mode) begin
      state_nxt   = S_ON;
      mode_nxt    = req;
      phase_start = 1'b1;
    end else begin
      unique case (state)
        S_ON: if (dur == on_lim) begin
          state_nxt   = S_OFF;
          phase_start = 1'b1;
        end
        S_OFF: if (dur == off_lim) begin
          state_nxt   = (req == 3'd0) ? S_IDLE : S_ON;
          mode_nxt    = req;
          phase_start = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin : outputs
    beep_on = (state == S_ON);
`ifdef PIEZO_MUTE_EN
    drive   = tone && (state == S_ON) && !(mute && active_mode != 3'd4);
`else
    drive   = tone && (state == S_ON);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin : state_reg
    if (!rst_n) begin
      state       <= S_IDLE;
      active_mode <= 3'd0;
      dur         <= '0;
      div         <= '0;
      tone        <= 1'b0;
      piezo       <= 1'b0;
      piezo_n     <= 1'b1;
    end else begin
      state       <= state_nxt;
      active_mode <= mode_nxt;
      dur         <= (phase_start || state_nxt == S_IDLE) ? '0 : dur + 1'b1;
      // Tone only runs while staying in ON; any entry to ON starts it from a clean low half.
      if (state_nxt != S_ON || phase_start) begin
        div  <= '0;
        tone <= 1'b0;
      end else if (div == half_lim) begin
        div  <= '0;
        tone <= ~tone;
      end else begin
        div  <= div + 1'b1;
      end
      piezo   <= drive;
      piezo_n <= ~drive;
    end
  end

endmodule

// File: tb/tb_piezo_alert_seq.sv
// Self-checking bench for piezo_alert_seq: directed scenarios then random input traffic,
// compared every cycle against a time-based behavioural model. Define PIEZO_MUTE_EN to cover mute.
module tb_piezo_alert_seq;

  localparam int HALF_N = 2, HALF_B = 2, HALF_O = 2;
  localparam int NORM_ON = 8, NORM_OFF = 24, OVR_ON = 8, OVR_OFF = 8, BOTH_ON = 4, BOTH_OFF = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, norm_mode = 1'b0, ovr_spd = 1'b0, batt_low = 1'b0;
`ifdef PIEZO_MUTE_EN
  logic       mute = 1'b0;
`endif
  logic       piezo, piezo_n, beep_on;
  logic [2:0] active_mode;

  always #5 clk = ~clk;

  piezo_alert_seq #(
    .NORM_HALF(HALF_N), .BATT_HALF(HALF_B), .OVR_HALF(HALF_O),
    .NORM_ON(NORM_ON), .NORM_OFF(NORM_OFF), .OVR_ON(OVR_ON), .OVR_OFF(OVR_OFF),
    .BOTH_ON(BOTH_ON), .BOTH_OFF(BOTH_OFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .norm_mode(norm_mode), .ovr_spd(ovr_spd), .batt_low(batt_low),
`ifdef PIEZO_MUTE_EN
    .mute(mute),
`endif
    .piezo(piezo), .piezo_n(piezo_n), .active_mode(active_mode), .beep_on(beep_on)
  );

  int n_vec = 0, n_err = 0, n_cyc = 0;

  // Reference model: phase, latched mode and clocks elapsed in the current phase.
  typedef enum {P_IDLE, P_ON, P_OFF} phase_t;
  phase_t m_phase = P_IDLE;
  int     m_mode = 0, m_t = 0;
  bit     m_piezo = 1'b0;

  function automatic int half_of(int mode);
    case (mode)
      1: return HALF_N;
      2: return HALF_B;
      3, 4: return HALF_O;
      default: return 1;
    endcase
  endfunction

  function automatic int on_len(int mode);
    return (mode == 4) ? BOTH_ON : (mode == 3) ? OVR_ON : NORM_ON;
  endfunction

  function automatic int off_len(int mode);
    return (mode == 4) ? BOTH_OFF : (mode == 3) ? OVR_OFF : NORM_OFF;
  endfunction

  task automatic model_step();
    int req;
    bit muted;
    req = (ovr_spd && batt_low) ? 4 : ovr_spd ? 3 : batt_low ? 2 : norm_mode ? 1 : 0;
`ifdef PIEZO_MUTE_EN
    muted = mute && (m_mode != 4);
`else
    muted = 1'b0;
`endif
    if (!rst_n) begin
      m_phase = P_IDLE; m_mode = 0; m_t = 0; m_piezo = 1'b0;
      return;
    end
    // Tone is high during odd half-periods counted from ON entry; piezo shows it one clk later.
    m_piezo = (m_phase == P_ON) && (((m_t / half_of(m_mode)) % 2) == 1) && !muted;
    if (req > m_mode) begin
      m_phase = P_ON; m_mode = req; m_t = 0;
    end else if (m_phase == P_ON) begin
      m_t++;
      if (m_t == on_len(m_mode)) begin m_phase = P_OFF; m_t = 0; end
    end else if (m_phase == P_OFF) begin
      m_t++;
      if (m_t == off_len(m_mode)) begin
        m_phase = (req == 0) ? P_IDLE : P_ON;
        m_mode  = req;
        m_t     = 0;
      end
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cycle %0d: observed %0d expected %0d", tag, n_cyc, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    n_cyc++;
    @(negedge clk);
    check("piezo", 32'(piezo), 32'(m_piezo));
    check("piezo_n", 32'(piezo_n), 32'(!m_piezo));
    check("active_mode", 32'(active_mode), 32'(m_mode));
    check("beep_on", 32'(beep_on), 32'(m_phase == P_ON));
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  // Advance until the model is t clocks into an ON phase; bounded.
  task automatic wait_on(int t);
    bit hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (m_phase == P_ON && m_t == t) hit = 1'b1;
      else cycle();
    end
    check("wait_on_timeout", 32'(hit), 32'd1);
  endtask

  initial begin
    // Reset for two clocks.
    rst_n = 1'b0;
    run(2);
    check("rst_piezo", 32'(piezo), 32'd0);
    check("rst_piezo_n", 32'(piezo_n), 32'd1);
    check("rst_mode", 32'(active_mode), 32'd0);
    check("rst_beep", 32'(beep_on), 32'd0);
    rst_n = 1'b1;
    run(2);

    // Normal mode: 8 on / 24 off, latency checks on beep_on and first piezo high.
    norm_mode = 1'b1;
    cycle();
    check("norm_beep_latency", 32'(beep_on), 32'd1);
    run(2);
    check("norm_piezo_low_early", 32'(piezo), 32'd0);
    cycle();
    check("norm_piezo_first_high", 32'(piezo), 32'd1);
    run(40);

    // Glitch on rst_n between edges during ON must be ignored.
    wait_on(3);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    cycle();
    check("glitch_mode", 32'(active_mode), 32'd1);
    check("glitch_beep", 32'(beep_on), 32'd1);

    // Escalation to over-speed during norm ON.
    wait_on(4);
    ovr_spd = 1'b1;
    cycle();
    check("escalate_mode", 32'(active_mode), 32'd3);
    run(20);

    // Drop over-speed mid-ON: the 8+8 pattern completes before returning to norm.
    wait_on(3);
    ovr_spd = 1'b0;
    run(12);
    check("deesc_deferred", 32'(active_mode), 32'd3);
    run(20);

    // Low battery alone.
    batt_low = 1'b1;
    run(45);
    batt_low = 1'b0;
    run(40);

    // Both warnings, then clear all: IDLE after the current pattern.
    ovr_spd = 1'b1; batt_low = 1'b1;
    cycle();
    check("both_mode", 32'(active_mode), 32'd4);
    run(10);
    ovr_spd = 1'b0; batt_low = 1'b0; norm_mode = 1'b0;
    run(14);
    check("idle_after_clear", 32'(active_mode), 32'd0);

    // Reset mid-beep.
    norm_mode = 1'b1;
    run(5);
    rst_n = 1'b0;
    cycle();
    check("rst_mid_beep", 32'(beep_on), 32'd0);
    rst_n = 1'b1;
    run(3);

`ifdef PIEZO_MUTE_EN
    norm_mode = 1'b0; batt_low = 1'b1; mute = 1'b1;
    run(60);
    ovr_spd = 1'b1;
    run(20);
    mute = 1'b0; ovr_spd = 1'b0; batt_low = 1'b0;
    run(20);
`endif

    // Random traffic with occasional reset.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        logic [2:0] v;
        v = 3'($urandom_range(0, 7));
        norm_mode = v[0]; ovr_spd = v[1]; batt_low = v[2];
      end
`ifdef PIEZO_MUTE_EN
      if ($urandom_range(0, 15) == 0) mute = ~mute;
`endif
      rst_n = ($urandom_range(0, 199) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
